// File: rtl/ex_flow_ctrl_unit_pkg.sv
// Shared encodings for the EX-stage control-flow unit: FSM states, op decode
// with call > ret > loop priority, and reset defaults.
package ex_flow_ctrl_unit_pkg;

  localparam int          ADDR_W_DEFAULT  = 8;
  localparam logic [7:0]  SP_INIT_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH     = 2'd1,
    ST_POP      = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Listed in priority order, highest first after OP_NONE.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CALL = 2'd1,
    OP_RET  = 2'd2,
    OP_LOOP = 2'd3
  } op_t;

  function automatic op_t decode_op(input logic is_call, input logic is_ret,
                                    input logic is_loop);
    if (is_call)      return OP_CALL;
    else if (is_ret)  return OP_RET;
    else if (is_loop) return OP_LOOP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/ex_flow_ctrl_unit_if.sv
// Data-memory stack port: the control-flow unit is master, the memory is slave.
interface ex_flow_ctrl_unit_if #(parameter int ADDR_W = 8);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/ex_flow_ctrl_unit_stack_ptr.sv
// Stack pointer register with wrapping inc/dec and a sticky over/underflow flag.
module ex_flow_ctrl_unit_stack_ptr #(
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= SP_INIT;
      stack_err <= 1'b0;
    end else if (inc) begin
      sp <= sp + ONE;
      if (sp == SP_INIT) stack_err <= 1'b1;
    end else if (dec) begin
      sp <= sp - ONE;
      if (sp == '0) stack_err <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_flow_ctrl_unit.sv
// EX-stage control-flow unit: multi-cycle CALL/RET through the memory stack,
// single-cycle LOOP, and the stall/flush/redirect feedback into IF/ID and ID/EX.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | decode; LOOP completes here, CALL/RET stall and move on
// PUSH     | write return address at SP, hold request until mem_ready
// POP      | read return address at SP, hold request until mem_ready
// REDIRECT | load PC with target, flush IF/ID and the held ID/EX op
module ex_flow_ctrl_unit
  import ex_flow_ctrl_unit_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_call_in,
  input  logic              is_ret_in,
  input  logic              is_loop_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] rdata1_in,
  input  logic [ADDR_W-1:0] rdata2_in,
  input  logic [1:0]        ra_in,
  ex_flow_ctrl_unit_if.master mem,
  output logic              loop_wr_en,
  output logic [1:0]        loop_wr_reg,
  output logic [ADDR_W-1:0] loop_wr_data,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  op_t               op;
  logic [ADDR_W-1:0] ret_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] sp;
  logic              sp_inc;
  logic              sp_dec;

  assign op     = decode_op(is_call_in, is_ret_in, is_loop_in);
  assign sp_inc = (state == ST_IDLE) && (op == OP_RET);
  assign sp_dec = (state == ST_PUSH) && mem.mem_ready;
  assign sp_out = sp;

  ex_flow_ctrl_unit_stack_ptr #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_stack_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (sp_inc),
    .dec       (sp_dec),
    .sp        (sp),
    .stack_err (stack_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ret_q <= '0;
      tgt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op == OP_CALL) begin
            ret_q <= pc_in + ONE;
            tgt_q <= rdata2_in;
            state <= ST_PUSH;
          end else if (op == OP_RET) begin
            state <= ST_POP;
          end
        end
        ST_PUSH: if (mem.mem_ready) state <= ST_REDIRECT;
        ST_POP: begin
          if (mem.mem_ready) begin
            tgt_q <= mem.mem_rdata;
            state <= ST_REDIRECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LOOP and the CALL/RET decode-cycle stall depend on the live ID/EX fields.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = sp;
    mem.mem_wdata = '0;
    loop_wr_en    = 1'b0;
    loop_wr_reg   = 2'd0;
    loop_wr_data  = '0;
    stall         = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    redir_valid   = 1'b0;
    redir_addr    = '0;
    case (state)
      ST_IDLE: begin
        if (op == OP_CALL || op == OP_RET) begin
          stall = 1'b1;
        end else if (op == OP_LOOP) begin
          loop_wr_en   = 1'b1;
          loop_wr_reg  = ra_in;
          loop_wr_data = rdata1_in - ONE;
          if (rdata1_in != ONE) begin
            redir_valid = 1'b1;
            redir_addr  = rdata2_in;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
          end
        end
      end
      ST_PUSH: begin
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = ret_q;
      end
      ST_POP: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
      end
      default: begin
        redir_valid = 1'b1;
        redir_addr  = tgt_q;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_flow_ctrl_unit.sv
// Directed bench for ex_flow_ctrl_unit: CALL/RET sequencing, wait states,
// LOOP cases, op priority, reset abort and sticky stack error.
module tb_ex_flow_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       is_call_in, is_ret_in, is_loop_in;
  logic [7:0] pc_in, rdata1_in, rdata2_in;
  logic [1:0] ra_in;
  logic       loop_wr_en;
  logic [1:0] loop_wr_reg;
  logic [7:0] loop_wr_data;
  logic       stall, flush_ifid, flush_idex, redir_valid;
  logic [7:0] redir_addr, sp_out;
  logic       stack_err;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  ex_flow_ctrl_unit_if #(.ADDR_W(8)) mem_bus ();

  ex_flow_ctrl_unit dut (
    .clk          (clk),
    .rst          (rst),
    .is_call_in   (is_call_in),
    .is_ret_in    (is_ret_in),
    .is_loop_in   (is_loop_in),
    .pc_in        (pc_in),
    .rdata1_in    (rdata1_in),
    .rdata2_in    (rdata2_in),
    .ra_in        (ra_in),
    .mem          (mem_bus.master),
    .loop_wr_en   (loop_wr_en),
    .loop_wr_reg  (loop_wr_reg),
    .loop_wr_data (loop_wr_data),
    .stall        (stall),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .redir_valid  (redir_valid),
    .redir_addr   (redir_addr),
    .sp_out       (sp_out),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ops();
    is_call_in = 1'b0;
    is_ret_in  = 1'b0;
    is_loop_in = 1'b0;
  endtask

  typedef struct {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [1:0] ra;
    logic [7:0] exp_data;
    logic       exp_redir;
  } loop_vec_t;

  loop_vec_t loop_vecs[3] = '{
    '{8'h03, 8'h20, 2'd2, 8'h02, 1'b1},
    '{8'h01, 8'h30, 2'd1, 8'h00, 1'b0},
    '{8'h00, 8'h44, 2'd3, 8'hFF, 1'b1}
  };

  initial begin
    rst = 1'b1;
    clear_ops();
    pc_in = '0; rdata1_in = '0; rdata2_in = '0; ra_in = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check_val("rst_sp",      sp_out,           8'hFF);
    check_val("rst_addr",    mem_bus.mem_addr, 8'hFF);
    check_val("rst_req",     mem_bus.mem_req,  0);
    check_val("rst_stall",   stall,            0);
    check_val("rst_redir",   redir_valid,      0);
    check_val("rst_err",     stack_err,        0);

    // CALL pc=10 -> push 11 at FF, redirect to 40
    is_call_in = 1'b1; pc_in = 8'h10; rdata2_in = 8'h40; mem_bus.mem_ready = 1'b1;
    settle();
    check_val("call_dec_stall", stall, 1);
    check_val("call_dec_req",   mem_bus.mem_req, 0);
    tick();
    check_val("call_push_req",   mem_bus.mem_req,   1);
    check_val("call_push_we",    mem_bus.mem_we,    1);
    check_val("call_push_addr",  mem_bus.mem_addr,  8'hFF);
    check_val("call_push_wdata", mem_bus.mem_wdata, 8'h11);
    check_val("call_push_stall", stall,             1);
    tick();
    check_val("call_redir_v",  redir_valid, 1);
    check_val("call_redir_a",  redir_addr,  8'h40);
    check_val("call_flush_if", flush_ifid,  1);
    check_val("call_flush_ex", flush_idex,  1);
    check_val("call_stall0",   stall,       0);
    check_val("call_sp",       sp_out,      8'hFE);
    clear_ops();
    tick();
    check_val("call_done_redir", redir_valid, 0);

    // RET pops 11 from FF
    is_ret_in = 1'b1; mem_bus.mem_rdata = 8'h11; stall_cnt = 0;
    settle();
    stall_cnt += int'(stall);
    tick();
    stall_cnt += int'(stall);
    check_val("ret_sp",   sp_out,           8'hFF);
    check_val("ret_req",  mem_bus.mem_req,  1);
    check_val("ret_we",   mem_bus.mem_we,   0);
    check_val("ret_addr", mem_bus.mem_addr, 8'hFF);
    tick();
    stall_cnt += int'(stall);
    check_val("ret_redir_v", redir_valid, 1);
    check_val("ret_redir_a", redir_addr,  8'h11);
    check_val("ret_stall_cycles", stall_cnt, 2);
    check_val("ret_err", stack_err, 0);
    clear_ops();
    tick();

    // CALL with three wait cycles
    is_call_in = 1'b1; pc_in = 8'h20; rdata2_in = 8'h55; mem_bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("wait%0d_req", i),   mem_bus.mem_req,   1);
      check_val($sformatf("wait%0d_addr", i),  mem_bus.mem_addr,  8'hFF);
      check_val($sformatf("wait%0d_wdata", i), mem_bus.mem_wdata, 8'h21);
      check_val($sformatf("wait%0d_stall", i), stall,             1);
      check_val($sformatf("wait%0d_sp", i),    sp_out,            8'hFF);
      check_val($sformatf("wait%0d_redir", i), redir_valid,       0);
      tick();
    end
    mem_bus.mem_ready = 1'b1;
    settle();
    check_val("wait_rdy_req", mem_bus.mem_req, 1);
    tick();
    check_val("wait_redir_a", redir_addr, 8'h55);
    check_val("wait_sp",      sp_out,     8'hFE);
    clear_ops();
    tick();

    // LOOP vectors, all combinational in IDLE
    is_loop_in = 1'b1;
    foreach (loop_vecs[i]) begin
      rdata1_in = loop_vecs[i].r1; rdata2_in = loop_vecs[i].r2; ra_in = loop_vecs[i].ra;
      settle();
      check_val($sformatf("loop%0d_en", i),    loop_wr_en,   1);
      check_val($sformatf("loop%0d_reg", i),   loop_wr_reg,  loop_vecs[i].ra);
      check_val($sformatf("loop%0d_data", i),  loop_wr_data, loop_vecs[i].exp_data);
      check_val($sformatf("loop%0d_redir", i), redir_valid,  loop_vecs[i].exp_redir);
      check_val($sformatf("loop%0d_raddr", i), redir_addr,
                loop_vecs[i].exp_redir ? loop_vecs[i].r2 : 8'h00);
      check_val($sformatf("loop%0d_flush", i), flush_idex,   loop_vecs[i].exp_redir);
      check_val($sformatf("loop%0d_stall", i), stall,        0);
    end
    tick();
    check_val("loop_no_mem", mem_bus.mem_req, 0);
    clear_ops();
    settle();

    // CALL+LOOP together runs CALL only; ret address wraps FF->00
    is_call_in = 1'b1; is_loop_in = 1'b1; pc_in = 8'hFF; rdata1_in = 8'h05;
    rdata2_in = 8'h60; mem_bus.mem_ready = 1'b0;
    settle();
    check_val("prio_loop_en", loop_wr_en,  0);
    check_val("prio_redir",   redir_valid, 0);
    check_val("prio_stall",   stall,       1);
    tick();
    check_val("prio_push_we",    mem_bus.mem_we,    1);
    check_val("prio_push_wdata", mem_bus.mem_wdata, 8'h00);
    check_val("prio_push_addr",  mem_bus.mem_addr,  8'hFE);
    tick();
    // reset during the PUSH wait
    rst = 1'b1;
    tick();
    rst = 1'b0; clear_ops(); mem_bus.mem_ready = 1'b1;
    settle();
    check_val("abort_req",   mem_bus.mem_req, 0);
    check_val("abort_sp",    sp_out,          8'hFF);
    check_val("abort_redir", redir_valid,     0);
    check_val("abort_stall", stall,           0);
    tick();
    check_val("abort_redir2", redir_valid, 0);
    check_val("abort_sp2",    sp_out,      8'hFF);

    // RET from empty stack: wrap to 00 and sticky error
    is_ret_in = 1'b1; mem_bus.mem_rdata = 8'h33;
    tick();
    check_val("uflow_sp",   sp_out,           8'h00);
    check_val("uflow_err",  stack_err,        1);
    check_val("uflow_addr", mem_bus.mem_addr, 8'h00);
    tick();
    check_val("uflow_redir", redir_addr, 8'h33);
    clear_ops();
    tick();
    is_loop_in = 1'b1; rdata1_in = 8'h02; rdata2_in = 8'h70;
    tick();
    clear_ops();
    is_call_in = 1'b1; pc_in = 8'h05; rdata2_in = 8'h08;
    tick(); tick();
    clear_ops();
    tick();
    check_val("err_sticky", stack_err, 1);
    check_val("err_sp",     sp_out,    8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_val("err_cleared", stack_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_flow_ctrl_unit.md
Name: ex_flow_ctrl_unit

Overview:
EX-stage consumer of the ID/EX pipeline register's control-flow fields (is_call, is_ret, is_loop, pc, rdata1/2, ra).
- Sequences multi-cycle CALL/RET through the data-memory stack; the unit owns the 8-bit SP.
- Executes single-cycle LOOP (decrement and branch).
- Drives stall, flush and PC-redirect back into IF/ID and ID/EX, closing the loop on the ID/EX flush input.

Parameters:
SP_INIT, 8'hFF, stack pointer reset value (empty stack); pushes move SP downward
ADDR_W, 8, PC, SP and data-memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
is_call_in  in  1  ID/EX is_call_out
is_ret_in  in  1  ID/EX is_ret_out
is_loop_in  in  1  ID/EX is_loop_out
pc_in  in  8  PC of the EX instruction
rdata1_in  in  8  Ra value (loop counter)
rdata2_in  in  8  Rb value (CALL/LOOP target)
ra_in  in  2  Ra index (loop counter register)
mem_req  out  1  data-memory request valid
mem_we  out  1  1 = write (push), 0 = read (pop)
mem_addr  out  8  stack address
mem_wdata  out  8  return address being pushed
mem_ready  in  1  memory accepts / returns data this cycle
mem_rdata  in  8  pop data, valid when mem_req && !mem_we && mem_ready
loop_wr_en  out  1  register-file write strobe for the decremented counter
loop_wr_reg  out  2  destination register = ra_in
loop_wr_data  out  8  rdata1_in - 1, modulo 256
stall  out  1  hold PC, IF/ID and ID/EX
flush_ifid  out  1  squash IF/ID
flush_idex  out  1  drives ID/EX flush
redir_valid  out  1  load PC with redir_addr
redir_addr  out  8  new PC
sp_out  out  8  current SP, for debug and IO
stack_err  out  1  sticky: push at SP==8'h00 or pop at SP==SP_INIT

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, SP=SP_INIT, stack_err=0, latched target/return cleared. All outputs 0 except sp_out=SP_INIT and mem_addr=SP.
- Reset mid-transaction aborts the transaction: mem_req is low the next cycle, no SP update, no redirect.
- States: IDLE, PUSH, POP, REDIRECT.
- Op priority when more than one is_* flag is set: call > ret > loop. Lower-priority flags are ignored.
- IDLE + is_call:
  - stall=1 combinationally.
  - Latch ret=pc_in+1 (wraps 8'hFF->8'h00) and tgt=rdata2_in.
  - Next state PUSH.
- IDLE + is_ret:
  - stall=1 combinationally.
  - SP<=SP+1 (wrap); stack_err<=1 if SP==SP_INIT.
  - Next state POP.
- PUSH:
  - stall=1; mem_req=1, mem_we=1, mem_addr=SP, mem_wdata=ret, all held stable until mem_ready.
  - On mem_ready: SP<=SP-1 (wrap); stack_err<=1 if SP was 8'h00; next state REDIRECT.
- POP:
  - stall=1; mem_req=1, mem_we=0, mem_addr=SP.
  - On mem_ready: tgt<=mem_rdata; next state REDIRECT.
- REDIRECT:
  - stall=0, redir_valid=1, redir_addr=tgt, flush_ifid=1, flush_idex=1 (removes the held CALL/RET).
  - Next state IDLE.
- IDLE + is_loop (single cycle, combinational, no stall):
  - loop_wr_en=1, loop_wr_reg=ra_in, loop_wr_data=rdata1_in-1.
  - If rdata1_in != 8'h01: redir_valid=1, redir_addr=rdata2_in, flush_ifid=1, flush_idex=1.
  - rdata1_in==8'h00 decrements to 8'hFF and branches (wrap, no special case).
- Inputs are ignored outside IDLE; the instruction is held in ID/EX by stall.
- mem_ready is ignored while mem_req=0.
- Latency with mem_ready=1 on first request: CALL and RET each occupy 3 cycles (IDLE decode, PUSH/POP, REDIRECT); redirect appears 2 cycles after the op reaches EX. Each wait cycle adds 1.
- stack_err is cleared only by rst.

Decomposition:
- Shared control package/include:
  - state encodings IDLE=2'd0, PUSH=2'd1, POP=2'd2, REDIRECT=2'd3
  - SP_INIT default
  - op-priority constants
- No sub-module required. An optional stack_ptr sub-module (SP register, inc/dec, wrap and error detection) keeps the FSM clean.

Test Plan:
- Reset, then CALL at pc=8'h10, rdata2=8'h40, mem_ready=1 -> cycle+1: mem_req/we=1, addr=8'hFF, wdata=8'h11. Cycle+2: redir 8'h40 with both flushes. SP=8'hFE.
- RET after that CALL, mem_rdata=8'h11 -> SP=8'hFF, read at addr 8'hFF, redir_addr=8'h11. stall is high for exactly 2 cycles.
- CALL with mem_ready low for 3 cycles -> mem_req/addr/wdata stable throughout, stall held, SP unchanged until the ready cycle.
- LOOP rdata1=8'h03, rdata2=8'h20, ra=2 -> loop_wr_data=8'h02, wr_reg=2, redir 8'h20 same cycle. Repeat with rdata1=8'h01 -> wr_data=8'h00, no redirect.
- RET from reset (SP=8'hFF) -> SP=8'h00 (wrap), stack_err=1 and stays set through later ops until rst.
- rst asserted in the PUSH wait state -> next cycle state IDLE, mem_req=0, SP=SP_INIT, no redirect. A simultaneous is_call+is_loop executes as CALL only.
